iter_alu: RTL and testbench
===========================

# iter_alu

Multi-cycle integer execution unit that consumes the 5-bit `ALUop` code produced by the control path's ALU decoder, together with two 32-bit operands. It returns a registered result. Arithmetic, logic, compare, LUI and branch-condition ops complete in one cycle. Shifts (one bit per cycle) and CLZ/CLO (one bit scanned per cycle) iterate. It sits in the execute stage behind a valid/ready handshake, so the pipeline stalls on `in_ready` while an iterative op runs.

## Interface
Parameters:
- `WIDTH`, 32: operand/result width. Only 32 is supported; the shift count field is fixed at 5 bits.

Ports:
- `clk`  in  1  clock; all state changes on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `in_valid`  in  1  operation request.
- `in_ready`  out  1  unit idle, can accept.
- `ALUop`  in  5  operation code; encodings per `ALUop.vh`.
- `A`  in  32  operand A (rs). For shifts, `A[4:0]` is the shift amount.
- `B`  in  32  operand B (rt/immediate). Shifts operate on B.
- `out_valid`  out  1  result available.
- `out_ready`  in  1  consumer takes result.
- `result`  out  32  registered result.
- `overflow`  out  1  signed overflow for `ALU_ADD`/`ALU_SUB`; 0 for all other ops.
- `illegal`  out  1  `ALUop` was `ALU_XXX` or an undefined code.

## Operation
- FSM states: IDLE, SHIFT, COUNT, DONE. `in_ready` = (state==IDLE) & ~rst.
- Accept occurs when `in_valid & in_ready`. On accept, operands and `ALUop` are latched, and the inputs are then don't-care.
- Single-cycle ops go IDLE→DONE on the accept edge, with `result` computed as follows:
  - ADD/ADDU/SUB/SUBU: mod 2^32.
  - AND/OR/XOR/NOR: bitwise.
  - SLT: signed compare; SLTU: unsigned compare.
  - LUI: {B[15:0],16'h0}.
  - BEQ (A==B), BNE (A!=B): result = {31'b0,cond}.
  - BLEZ, BGTZ, BLTZ, BGEZ: signed test of A against 0, B ignored; result = {31'b0,cond}.
- Overflow: ADD sets it when A and B have equal signs and the result sign differs. SUB sets it when A and B have different signs and the result sign differs from A. The result is still written.
- Illegal op: go to DONE with `result`=0 and `illegal`=1.
- Shift ops (SLL/SRL/SRA):
  - If A[4:0]==0: go to DONE with `result`=B.
  - Otherwise: load shreg=B and cnt=A[4:0], then go to SHIFT. Each SHIFT edge shifts by 1 and decrements cnt. The edge where cnt==1 moves to DONE.
  - SRL fills with 0. SRA fills with shreg[31], the original B sign.
- CLZ/CLO: load shreg=A, cnt(6b)=0, target bit (0 for CLZ, 1 for CLO), then go to COUNT. On each COUNT edge:
  - If cnt==32 or shreg[31]!=target: go to DONE with `result`={26'b0,cnt}.
  - Otherwise: shreg<<=1 and cnt++.
- DONE: `out_valid`=1, and `result`/`overflow`/`illegal` are held stable. When `out_valid & out_ready`, return to IDLE. No new accept happens in the same cycle.
- Reset (any state, including mid-iteration):
  - State goes to IDLE and the in-flight op is discarded.
  - `out_valid`=0, `result`=0, `overflow`=0, `illegal`=0, `in_ready`=0 while `rst` is high.
  - `in_ready`=1 in the first cycle after `rst` falls.

## Timing
- Latency L is counted from the accept cycle to the first `out_valid` cycle:
  - Single-cycle/illegal: L=1.
  - Shift by n: L=1 if n=0, else L=n+1 (max 32).
  - CLZ/CLO with result k: L=k+2 (k<32). For k=32, L=34.
- Throughput: one op per L+1 cycles with `out_ready` held high, because the DONE→IDLE edge costs one cycle.
- `out_ready` low in DONE stalls indefinitely. Outputs must not change while stalled.
- `out_ready` outside DONE is ignored. `in_valid` outside IDLE is ignored, and the op is not captured.

## Test plan
- ADD with A=32'h7FFFFFFF, B=1 → L=1, `result`=32'h80000000, `overflow`=1. The same operands with ADDU → `overflow`=0.
- SRA with A=4, B=32'hF0000000 → `out_valid` 5 cycles after accept, `result`=32'hFF000000. SLL with A=0, B=32'h1234 → L=1, `result`=32'h1234.
- CLZ with A=32'h00010000 → `result`=15, L=17. CLO with A=32'hFFFFFFFF → `result`=32, L=34. CLZ with A=0 → `result`=32.
- BLEZ with A=0 → `result`=1. BGTZ with A=32'h80000000 → `result`=0. SLTU with A=1, B=32'hFFFFFFFF → 1. SLT with the same operands → 0.
- Backpressure: hold `out_ready`=0 for 10 cycles in DONE → outputs stable, `in_ready`=0, and a pulsed `in_valid` is not captured. Release → IDLE the next cycle.
- Assert `rst` during the 3rd SHIFT cycle of a 20-bit SLL → next cycle `out_valid`=0 and `result`=0. After `rst` falls, `in_ready`=1, and a new ANDI-class AND op completes with L=1. Illegal `ALUop` → `illegal`=1, `result`=0.

Source files
------------

// File: rtl/iter_alu.sv
// iter_alu: multi-cycle integer execution unit.
// Arithmetic, logic, compare, LUI and branch-condition ops finish in one
// cycle. Shifts move one bit per cycle, and CLZ/CLO scan one bit per cycle.
// The result is held in DONE until the consumer takes it.
module iter_alu #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [4:0]       ALUop,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             overflow,
    output logic             illegal
);

    // ALU decoder encodings. Codes 22..30 are undefined, and 31 is ALU_XXX.
    localparam logic [4:0] ALU_ADD  = 5'd0,  ALU_ADDU = 5'd1,  ALU_SUB  = 5'd2;
    localparam logic [4:0] ALU_SUBU = 5'd3,  ALU_AND  = 5'd4,  ALU_OR   = 5'd5;
    localparam logic [4:0] ALU_XOR  = 5'd6,  ALU_NOR  = 5'd7,  ALU_SLT  = 5'd8;
    localparam logic [4:0] ALU_SLTU = 5'd9,  ALU_LUI  = 5'd10, ALU_SLL  = 5'd11;
    localparam logic [4:0] ALU_SRL  = 5'd12, ALU_SRA  = 5'd13, ALU_CLZ  = 5'd14;
    localparam logic [4:0] ALU_CLO  = 5'd15, ALU_BEQ  = 5'd16, ALU_BNE  = 5'd17;
    localparam logic [4:0] ALU_BLEZ = 5'd18, ALU_BGTZ = 5'd19, ALU_BLTZ = 5'd20;
    localparam logic [4:0] ALU_BGEZ = 5'd21;

    typedef enum logic [1:0] {IDLE, SHIFT, COUNT, DONE} state_t;

    state_t           state_reg, state_next;
    logic [4:0]       op_reg, op_next;
    logic [WIDTH-1:0] shreg_reg, shreg_next;
    logic [5:0]       cnt_reg, cnt_next;
    logic [WIDTH-1:0] result_reg, result_next;
    logic             ovf_reg, ovf_next;
    logic             ill_reg, ill_next;

    logic [WIDTH-1:0] sum, diff, shifted;
    logic             a_is_zero, count_target;

    assign sum       = A + B;
    assign diff      = A - B;
    assign a_is_zero = (A == '0);

    // One-bit step of the shift register for the latched shift op.
    always_comb begin
        shifted = shreg_reg << 1;
        if (op_reg == ALU_SRL)
            shifted = shreg_reg >> 1;
        else if (op_reg == ALU_SRA)
            shifted = {shreg_reg[WIDTH-1], shreg_reg[WIDTH-1:1]};
    end

    assign count_target = (op_reg == ALU_CLO);

    // Next-state and datapath update for accept, iteration and handoff.
    always_comb begin
        state_next  = state_reg;
        op_next     = op_reg;
        shreg_next  = shreg_reg;
        cnt_next    = cnt_reg;
        result_next = result_reg;
        ovf_next    = ovf_reg;
        ill_next    = ill_reg;
        case (state_reg)
            IDLE: begin
                if (in_valid) begin
                    op_next    = ALUop;
                    ovf_next   = 1'b0;
                    ill_next   = 1'b0;
                    state_next = DONE;
                    case (ALUop)
                        ALU_ADD: begin
                            result_next = sum;
                            ovf_next    = (A[WIDTH-1] == B[WIDTH-1]) && (sum[WIDTH-1] != A[WIDTH-1]);
                        end
                        ALU_ADDU: result_next = sum;
                        ALU_SUB: begin
                            result_next = diff;
                            ovf_next    = (A[WIDTH-1] != B[WIDTH-1]) && (diff[WIDTH-1] != A[WIDTH-1]);
                        end
                        ALU_SUBU: result_next = diff;
                        ALU_AND:  result_next = A & B;
                        ALU_OR:   result_next = A | B;
                        ALU_XOR:  result_next = A ^ B;
                        ALU_NOR:  result_next = ~(A | B);
                        ALU_SLT:  result_next = {{(WIDTH-1){1'b0}}, $signed(A) < $signed(B)};
                        ALU_SLTU: result_next = {{(WIDTH-1){1'b0}}, A < B};
                        ALU_LUI:  result_next = {B[15:0], 16'h0};
                        ALU_BEQ:  result_next = {{(WIDTH-1){1'b0}}, A == B};
                        ALU_BNE:  result_next = {{(WIDTH-1){1'b0}}, A != B};
                        ALU_BLEZ: result_next = {{(WIDTH-1){1'b0}}, A[WIDTH-1] | a_is_zero};
                        ALU_BGTZ: result_next = {{(WIDTH-1){1'b0}}, ~A[WIDTH-1] & ~a_is_zero};
                        ALU_BLTZ: result_next = {{(WIDTH-1){1'b0}}, A[WIDTH-1]};
                        ALU_BGEZ: result_next = {{(WIDTH-1){1'b0}}, ~A[WIDTH-1]};
                        ALU_SLL, ALU_SRL, ALU_SRA: begin
                            if (A[4:0] == 5'd0) begin
                                result_next = B;
                            end else begin
                                shreg_next = B;
                                cnt_next   = {1'b0, A[4:0]};
                                state_next = SHIFT;
                            end
                        end
                        ALU_CLZ, ALU_CLO: begin
                            shreg_next = A;
                            cnt_next   = 6'd0;
                            state_next = COUNT;
                        end
                        default: begin
                            result_next = '0;
                            ill_next    = 1'b1;
                        end
                    endcase
                end
            end
            SHIFT: begin
                shreg_next = shifted;
                cnt_next   = cnt_reg - 6'd1;
                if (cnt_reg == 6'd1) begin
                    result_next = shifted;
                    state_next  = DONE;
                end
            end
            COUNT: begin
                if (cnt_reg == 6'd32 || shreg_reg[WIDTH-1] != count_target) begin
                    result_next = {{(WIDTH-6){1'b0}}, cnt_reg};
                    state_next  = DONE;
                end else begin
                    shreg_next = shreg_reg << 1;
                    cnt_next   = cnt_reg + 6'd1;
                end
            end
            DONE: begin
                if (out_ready)
                    state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // State and datapath registers; reset discards any in-flight op.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg  <= IDLE;
            op_reg     <= 5'd0;
            shreg_reg  <= '0;
            cnt_reg    <= 6'd0;
            result_reg <= '0;
            ovf_reg    <= 1'b0;
            ill_reg    <= 1'b0;
        end else begin
            state_reg  <= state_next;
            op_reg     <= op_next;
            shreg_reg  <= shreg_next;
            cnt_reg    <= cnt_next;
            result_reg <= result_next;
            ovf_reg    <= ovf_next;
            ill_reg    <= ill_next;
        end
    end

    assign in_ready  = (state_reg == IDLE) && !rst;
    assign out_valid = (state_reg == DONE);
    assign result    = result_reg;
    assign overflow  = ovf_reg;
    assign illegal   = ill_reg;

endmodule

// File: tb/tb_iter_alu.sv
// Testbench for iter_alu: directed spot checks, random ops against a
// behavioural model, backpressure, throughput and mid-iteration reset.
module tb_iter_alu;

    localparam logic [4:0] ALU_ADD  = 5'd0,  ALU_ADDU = 5'd1,  ALU_SUB  = 5'd2;
    localparam logic [4:0] ALU_SUBU = 5'd3,  ALU_AND  = 5'd4,  ALU_OR   = 5'd5;
    localparam logic [4:0] ALU_XOR  = 5'd6,  ALU_NOR  = 5'd7,  ALU_SLT  = 5'd8;
    localparam logic [4:0] ALU_SLTU = 5'd9,  ALU_LUI  = 5'd10, ALU_SLL  = 5'd11;
    localparam logic [4:0] ALU_SRL  = 5'd12, ALU_SRA  = 5'd13, ALU_CLZ  = 5'd14;
    localparam logic [4:0] ALU_CLO  = 5'd15, ALU_BEQ  = 5'd16, ALU_BNE  = 5'd17;
    localparam logic [4:0] ALU_BLEZ = 5'd18, ALU_BGTZ = 5'd19, ALU_BLTZ = 5'd20;
    localparam logic [4:0] ALU_BGEZ = 5'd21, ALU_XXX  = 5'd31;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [4:0]  alu_op = 5'd0;
    logic [31:0] a_in = 32'h0;
    logic [31:0] b_in = 32'h0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [31:0] result;
    logic        overflow;
    logic        illegal;

    int total_cnt = 0;
    int pass_cnt  = 0;

    iter_alu #(.WIDTH(32)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .ALUop(alu_op), .A(a_in), .B(b_in), .out_valid(out_valid),
        .out_ready(out_ready), .result(result), .overflow(overflow), .illegal(illegal)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [4:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] res;
        logic        ovf;
        logic        ill;
        logic [7:0]  lat;
    } dir_t;

    dir_t dir_tab [18] = '{
        '{ALU_ADD,  32'h7FFFFFFF, 32'h1,        32'h80000000, 1'b1, 1'b0, 8'd1},
        '{ALU_ADDU, 32'h7FFFFFFF, 32'h1,        32'h80000000, 1'b0, 1'b0, 8'd1},
        '{ALU_SRA,  32'h4,        32'hF0000000, 32'hFF000000, 1'b0, 1'b0, 8'd5},
        '{ALU_SLL,  32'h0,        32'h1234,     32'h1234,     1'b0, 1'b0, 8'd1},
        '{ALU_CLZ,  32'h00010000, 32'h0,        32'd15,       1'b0, 1'b0, 8'd17},
        '{ALU_CLO,  32'hFFFFFFFF, 32'h0,        32'd32,       1'b0, 1'b0, 8'd34},
        '{ALU_CLZ,  32'h0,        32'h0,        32'd32,       1'b0, 1'b0, 8'd34},
        '{ALU_BLEZ, 32'h0,        32'h5,        32'd1,        1'b0, 1'b0, 8'd1},
        '{ALU_BGTZ, 32'h80000000, 32'h0,        32'd0,        1'b0, 1'b0, 8'd1},
        '{ALU_SLTU, 32'h1,        32'hFFFFFFFF, 32'd1,        1'b0, 1'b0, 8'd1},
        '{ALU_SLT,  32'h1,        32'hFFFFFFFF, 32'd0,        1'b0, 1'b0, 8'd1},
        '{ALU_SUB,  32'h80000000, 32'h1,        32'h7FFFFFFF, 1'b1, 1'b0, 8'd1},
        '{ALU_XXX,  32'h12345678, 32'h9,        32'h0,        1'b0, 1'b1, 8'd1},
        '{5'd25,    32'h1,        32'h1,        32'h0,        1'b0, 1'b1, 8'd1},
        '{ALU_LUI,  32'h0,        32'h0000ABCD, 32'hABCD0000, 1'b0, 1'b0, 8'd1},
        '{ALU_SRL,  32'h8,        32'h80000000, 32'h00800000, 1'b0, 1'b0, 8'd9},
        '{ALU_NOR,  32'h0,        32'h0,        32'hFFFFFFFF, 1'b0, 1'b0, 8'd1},
        '{ALU_SLL,  32'h1F,       32'h3,        32'h80000000, 1'b0, 1'b0, 8'd32}
    };

    // Reference model: result, overflow, illegal and latency from the op rules.
    task automatic model(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                         output logic [31:0] res, output logic ovf, output logic ill, output int lat);
        longint s;
        int k;
        res = 32'h0; ovf = 1'b0; ill = 1'b0; lat = 1;
        case (op)
            ALU_ADD: begin
                s = longint'($signed(a)) + longint'($signed(b));
                res = a + b;
                ovf = (s > 64'sd2147483647) || (s < -64'sd2147483648);
            end
            ALU_SUB: begin
                s = longint'($signed(a)) - longint'($signed(b));
                res = a - b;
                ovf = (s > 64'sd2147483647) || (s < -64'sd2147483648);
            end
            ALU_ADDU: res = a + b;
            ALU_SUBU: res = a - b;
            ALU_AND:  res = a & b;
            ALU_OR:   res = a | b;
            ALU_XOR:  res = a ^ b;
            ALU_NOR:  res = ~(a | b);
            ALU_SLT:  res = (int'(a) < int'(b)) ? 32'd1 : 32'd0;
            ALU_SLTU: res = (a < b) ? 32'd1 : 32'd0;
            ALU_LUI:  res = b << 16;
            ALU_BEQ:  res = (a == b) ? 32'd1 : 32'd0;
            ALU_BNE:  res = (a != b) ? 32'd1 : 32'd0;
            ALU_BLEZ: res = (int'(a) <= 0) ? 32'd1 : 32'd0;
            ALU_BGTZ: res = (int'(a) > 0) ? 32'd1 : 32'd0;
            ALU_BLTZ: res = (int'(a) < 0) ? 32'd1 : 32'd0;
            ALU_BGEZ: res = (int'(a) >= 0) ? 32'd1 : 32'd0;
            ALU_SLL: begin res = b << a[4:0]; lat = (a[4:0] == 0) ? 1 : int'(a[4:0]) + 1; end
            ALU_SRL: begin res = b >> a[4:0]; lat = (a[4:0] == 0) ? 1 : int'(a[4:0]) + 1; end
            ALU_SRA: begin res = 32'($signed(b) >>> a[4:0]); lat = (a[4:0] == 0) ? 1 : int'(a[4:0]) + 1; end
            ALU_CLZ, ALU_CLO: begin
                k = 0;
                while (k < 32 && a[31-k] == (op == ALU_CLO)) k++;
                res = 32'(k);
                lat = (k < 32) ? k + 2 : 34;
            end
            default: ill = 1'b1;
        endcase
    endtask

    // Issue one op with out_ready high; return outputs in the first DONE cycle.
    task automatic do_op(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                         output logic [31:0] res, output logic ovf, output logic ill, output int lat);
        int guard = 0;
        while (!in_ready && guard < 100) begin @(posedge clk); #1; guard++; end
        alu_op = op; a_in = a; b_in = b; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0; a_in = $urandom; b_in = $urandom; alu_op = 5'($urandom);
        lat = 1;
        while (!out_valid && lat < 100) begin @(posedge clk); #1; lat++; end
        res = result; ovf = overflow; ill = illegal;
        $display("op=%0d a=%h b=%h -> result=%h ovf=%0d ill=%0d lat=%0d", op, a, b, res, ovf, ill, lat);
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        total_cnt++; if (in_ready !== 1'b0) $display("FAIL reset_in_ready: got %b want 0", in_ready); else pass_cnt++;
        total_cnt++; if (out_valid !== 1'b0) $display("FAIL reset_out_valid: got %b want 0", out_valid); else pass_cnt++;
        total_cnt++; if ({result, overflow, illegal} !== 34'h0) $display("FAIL reset_outputs: got %h/%b/%b want 0", result, overflow, illegal); else pass_cnt++;
        rst = 1'b0;
        #1;
        total_cnt++; if (in_ready !== 1'b1) $display("FAIL reset_release_ready: got %b want 1", in_ready); else pass_cnt++;
    endtask

    task automatic test_directed();
        logic [31:0] res; logic ovf, ill; int lat;
        foreach (dir_tab[i]) begin
            do_op(dir_tab[i].op, dir_tab[i].a, dir_tab[i].b, res, ovf, ill, lat);
            total_cnt++;
            if (res !== dir_tab[i].res || ovf !== dir_tab[i].ovf || ill !== dir_tab[i].ill || lat != int'(dir_tab[i].lat))
                $display("FAIL directed_%0d: got res=%h ovf=%b ill=%b lat=%0d want res=%h ovf=%b ill=%b lat=%0d",
                         i, res, ovf, ill, lat, dir_tab[i].res, dir_tab[i].ovf, dir_tab[i].ill, dir_tab[i].lat);
            else pass_cnt++;
        end
    endtask

    task automatic test_random();
        logic [31:0] res, eres, a, b; logic ovf, ill, eovf, eill; int lat, elat;
        logic [4:0] op;
        for (int n = 0; n < 150; n++) begin
            op = 5'($urandom_range(0, 31));
            a = $urandom; b = $urandom;
            if ($urandom_range(0, 1) == 1) a = a >> $urandom_range(0, 32);
            if ($urandom_range(0, 3) == 0) a = ~a;
            if ($urandom_range(0, 7) == 0) b = a;
            model(op, a, b, eres, eovf, eill, elat);
            do_op(op, a, b, res, ovf, ill, lat);
            total_cnt++;
            if (res !== eres || ovf !== eovf || ill !== eill || lat != elat)
                $display("FAIL random_%0d op=%0d: got res=%h ovf=%b ill=%b lat=%0d want res=%h ovf=%b ill=%b lat=%0d",
                         n, op, res, ovf, ill, lat, eres, eovf, eill, elat);
            else pass_cnt++;
        end
    endtask

    task automatic test_backpressure();
        logic [31:0] held; int guard = 0; logic stable = 1'b1, busy = 1'b0;
        out_ready = 1'b0;
        alu_op = ALU_SRL; a_in = 32'd3; b_in = 32'hF0F0F0F0; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        while (!out_valid && guard < 100) begin @(posedge clk); #1; guard++; end
        held = result;
        total_cnt++; if (held !== 32'h1E1E1E1E) $display("FAIL bp_result: got %h want 1e1e1e1e", held); else pass_cnt++;
        for (int c = 0; c < 10; c++) begin
            if (c == 5) begin in_valid = 1'b1; alu_op = ALU_ADD; a_in = 32'd7; b_in = 32'd9; end
            @(posedge clk); #1;
            in_valid = 1'b0;
            if (result !== held || overflow !== 1'b0 || illegal !== 1'b0 || out_valid !== 1'b1) stable = 1'b0;
            if (in_ready !== 1'b0) busy = 1'b1;
        end
        total_cnt++; if (!stable) $display("FAIL bp_stable: got unstable outputs want held %h", held); else pass_cnt++;
        total_cnt++; if (busy) $display("FAIL bp_in_ready: got 1 want 0 while stalled"); else pass_cnt++;
        out_ready = 1'b1;
        @(posedge clk); #1;
        total_cnt++; if (out_valid !== 1'b0 || in_ready !== 1'b1) $display("FAIL bp_release: got out_valid=%b in_ready=%b want 0/1", out_valid, in_ready); else pass_cnt++;
        @(posedge clk); #1;
        total_cnt++; if (out_valid !== 1'b0 || result !== held) $display("FAIL bp_not_captured: got out_valid=%b result=%h want 0/%h", out_valid, result, held); else pass_cnt++;
    endtask

    task automatic test_back_to_back();
        logic [4:0] ops [2] = '{ALU_ADD, ALU_SLL};
        int lats [2] = '{1, 3};
        logic ok;
        for (int t = 0; t < 2; t++) begin
            ok = 1'b1;
            alu_op = ops[t]; a_in = 32'd2; b_in = 32'd5; in_valid = 1'b1;
            for (int c = 0; c < 3 * (lats[t] + 1); c++) begin
                if (in_ready !== ((c % (lats[t] + 1)) == 0)) ok = 1'b0;
                if (out_valid !== ((c % (lats[t] + 1)) == lats[t])) ok = 1'b0;
                @(posedge clk); #1;
            end
            in_valid = 1'b0;
            $display("back_to_back op=%0d period=%0d", ops[t], lats[t] + 1);
            total_cnt++; if (!ok) $display("FAIL b2b_op%0d: got wrong handshake pattern want period %0d", ops[t], lats[t] + 1); else pass_cnt++;
        end
    endtask

    task automatic test_reset_mid_shift();
        logic [31:0] res; logic ovf, ill; int lat;
        alu_op = ALU_SLL; a_in = 32'd20; b_in = 32'h1; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        total_cnt++; if (in_ready !== 1'b0) $display("FAIL rst_mid_in_ready: got %b want 0", in_ready); else pass_cnt++;
        @(posedge clk); #1;
        total_cnt++; if (out_valid !== 1'b0 || result !== 32'h0 || overflow !== 1'b0 || illegal !== 1'b0)
            $display("FAIL rst_mid_outputs: got ov=%b res=%h want 0/0", out_valid, result); else pass_cnt++;
        rst = 1'b0;
        #1;
        total_cnt++; if (in_ready !== 1'b1) $display("FAIL rst_mid_ready: got %b want 1", in_ready); else pass_cnt++;
        do_op(ALU_AND, 32'hFF00FF00, 32'h0000FFFF, res, ovf, ill, lat);
        total_cnt++; if (res !== 32'h0000FF00 || lat != 1) $display("FAIL rst_mid_and: got res=%h lat=%0d want 0000ff00/1", res, lat); else pass_cnt++;
        do_op(ALU_XXX, 32'h1, 32'h2, res, ovf, ill, lat);
        total_cnt++; if (res !== 32'h0 || ill !== 1'b1) $display("FAIL rst_mid_illegal: got res=%h ill=%b want 0/1", res, ill); else pass_cnt++;
    endtask

    initial begin
        test_reset();
        test_directed();
        test_random();
        test_backpressure();
        test_back_to_back();
        test_reset_mid_shift();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
